// File: rtl/bf16_exp2.sv
// Iterative bfloat16 antilog: 2^x by splitting x into integer/fraction parts and
// evaluating 2^F with a shift-and-add loop against a log2(1+2^-i) constant ROM.
module bf16_exp2 #(
  parameter int MAN    = 7,
  parameter int EXP    = 8,
  parameter int BIAS   = 127,
  parameter int FRAC_W = 16,
  parameter int ITER   = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sign,
  input  logic [EXP-1:0] exponent,
  input  logic [MAN-1:0] fractional,
  input  logic           input_valid,
  output logic           ready_o,
  output logic           s_res_o,
  output logic [EXP-1:0] e_res_o,
  output logic [MAN-1:0] f_res_o,
  output logic           valid_o
);
  localparam int MW = MAN + 1 + FRAC_W;
  localparam int IW = MAN + 3;
  localparam int SW = EXP + 2;
  localparam logic [EXP-1:0] E_ALL1 = {EXP{1'b1}};
  localparam logic [MAN-1:0] NAN_F  = {1'b1, {(MAN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, RUN, OUT_RES} state_t;

  state_t            state_reg;
  logic              sign_reg;
  logic [EXP-1:0]    exp_reg;
  logic [MAN-1:0]    frac_reg;
  logic [EXP-1:0]    e_keep_reg;
  logic [FRAC_W+1:0] y_reg;
  logic [FRAC_W-1:0] r_reg;
  logic [3:0]        it_reg;

  logic [SW-1:0]     sh_amt;
  logic [MW-1:0]     m_fix;
  logic [MAN:0]      int_part;
  logic [FRAC_W-1:0] frac_part;
  logic signed [IW-1:0] i_val;
  logic [FRAC_W-1:0] f_val;
  logic [IW:0]       e_val;
  logic              e_over;
  logic              e_under;
  logic              early;
  logic [EXP-1:0]    early_e;
  logic [MAN-1:0]    early_f;

  logic [FRAC_W-1:0] l_val;
  logic              take;
  logic [FRAC_W-1:0] r_step;
  logic [FRAC_W+1:0] y_step;
  logic [MAN-1:0]    f_pack;

  function automatic logic [15:0] l_rom(input logic [3:0] idx);
    case (idx)
      4'd1:    l_rom = 16'd38336;
      4'd2:    l_rom = 16'd21098;
      4'd3:    l_rom = 16'd11136;
      4'd4:    l_rom = 16'd5732;
      4'd5:    l_rom = 16'd2909;
      4'd6:    l_rom = 16'd1466;
      4'd7:    l_rom = 16'd736;
      4'd8:    l_rom = 16'd369;
      4'd9:    l_rom = 16'd184;
      4'd10:   l_rom = 16'd92;
      4'd11:   l_rom = 16'd46;
      4'd12:   l_rom = 16'd23;
      4'd13:   l_rom = 16'd12;
      4'd14:   l_rom = 16'd6;
      4'd15:   l_rom = 16'd3;
      default: l_rom = 16'd0;
    endcase
  endfunction

  // Operand classification and fixed-point split of the latched operand.
  always_comb begin
    sh_amt    = SW'(BIAS + MAN) - SW'(exp_reg);
    m_fix     = {1'b1, frac_reg, {FRAC_W{1'b0}}} >> sh_amt;
    int_part  = m_fix[MW-1:FRAC_W];
    frac_part = m_fix[FRAC_W-1:0];
    if (!sign_reg) begin
      i_val = $signed({2'b00, int_part});
      f_val = frac_part;
    end else if (frac_part == '0) begin
      i_val = -$signed({2'b00, int_part});
      f_val = '0;
    end else begin
      i_val = -$signed({2'b00, int_part}) - IW'(1);
      f_val = -frac_part;
    end
    e_val   = {i_val[IW-1], i_val} + (IW+1)'(BIAS);
    e_under = e_val[IW] || (e_val == '0);
    e_over  = !e_val[IW] && (e_val >= (IW+1)'(E_ALL1));

    early   = 1'b1;
    early_e = '0;
    early_f = '0;
    if (exp_reg == E_ALL1) begin
      if (frac_reg != '0) begin
        early_e = E_ALL1;
        early_f = NAN_F;
      end else if (!sign_reg) begin
        early_e = E_ALL1;
      end
    end else if (exp_reg == '0) begin
      early_e = EXP'(BIAS);
    end else if (exp_reg >= EXP'(BIAS + 8)) begin
      early_e = sign_reg ? '0 : E_ALL1;
    end else if (e_over) begin
      early_e = E_ALL1;
    end else if (!e_under) begin
      early = 1'b0;
    end
  end

  always_comb begin
    l_val  = FRAC_W'(l_rom(it_reg));
    take   = (r_reg >= l_val);
    r_step = take ? (r_reg - l_val) : r_reg;
    y_step = take ? (y_reg + (y_reg >> it_reg)) : y_reg;
    // y stays below 2.0 in practice; saturate rather than wrap if it ever reaches it
    f_pack = y_step[FRAC_W+1] ? {MAN{1'b1}} : y_step[FRAC_W-1 -: MAN];
  end

  assign ready_o = (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      frac_reg   <= '0;
      e_keep_reg <= '0;
      y_reg      <= '0;
      r_reg      <= '0;
      it_reg     <= '0;
      s_res_o    <= 1'b0;
      e_res_o    <= '0;
      f_res_o    <= '0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (input_valid) begin
            sign_reg  <= sign;
            exp_reg   <= exponent;
            frac_reg  <= fractional;
            state_reg <= PREP;
          end
        end
        PREP: begin
          y_reg      <= (FRAC_W+2)'(1) << FRAC_W;
          r_reg      <= f_val;
          it_reg     <= 4'd1;
          e_keep_reg <= e_val[EXP-1:0];
          if (early) begin
            s_res_o   <= 1'b0;
            e_res_o   <= early_e;
            f_res_o   <= early_f;
            valid_o   <= 1'b1;
            state_reg <= OUT_RES;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          y_reg  <= y_step;
          r_reg  <= r_step;
          it_reg <= it_reg + 4'd1;
          if (it_reg == 4'(ITER)) begin
            s_res_o   <= 1'b0;
            e_res_o   <= e_keep_reg;
            f_res_o   <= f_pack;
            valid_o   <= 1'b1;
            state_reg <= OUT_RES;
          end
        end
        OUT_RES: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf16_exp2.sv
// Bench for bf16_exp2: directed cases, real-arithmetic reference for random operands,
// back-to-back acceptance spacing and mid-operation reset.
`timescale 1ns/1ps
module tb_bf16_exp2;
  logic       clk = 1'b0;
  logic       rst;
  logic       sign;
  logic [7:0] exponent;
  logic [6:0] fractional;
  logic       input_valid;
  logic       ready_o;
  logic       s_res_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic       valid_o;

  int total = 0;
  int bad   = 0;

  bf16_exp2 dut (
    .clk(clk), .rst(rst), .sign(sign), .exponent(exponent), .fractional(fractional),
    .input_valid(input_valid), .ready_o(ready_o), .s_res_o(s_res_o), .e_res_o(e_res_o),
    .f_res_o(f_res_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic chk_tol(input string tag, input int got, input int want);
    int d;
    d = got - want;
    total++;
    assert ((d >= -1 && d <= 1) === 1'b1) else begin
      bad++;
      $error("FAIL %s: got code %0d want code %0d (+-1)", tag, got, want);
    end
  endtask

  // Reference: 2^x from the operand's real value; exponent = floor(x), fraction truncated.
  task automatic model(input bit s, input bit [7:0] e, input bit [6:0] f,
                       output int ee, output int ef, output int el);
    real x, fl, tm;
    int  ei;
    el = 2;
    ee = 0;
    ef = 0;
    if (e == 8'd255) begin
      if (f != 0) begin ee = 255; ef = 64; end
      else if (!s) ee = 255;
    end else if (e == 8'd0) begin
      ee = 127;
    end else if (int'(e) - 127 >= 8) begin
      ee = s ? 0 : 255;
    end else begin
      x = (1.0 + real'(f) / 128.0) * $pow(2.0, real'(int'(e) - 127));
      if (s) x = -x;
      fl = $floor(x);
      ei = int'(fl) + 127;
      if (ei >= 255) ee = 255;
      else if (ei <= 0) ee = 0;
      else begin
        tm = $pow(2.0, x - fl);
        ef = int'($floor((tm - 1.0) * 128.0));
        if (ef > 127) ef = 127;
        ee = ei;
        el = 14;
      end
    end
  endtask

  task automatic run_op(input bit s, input bit [7:0] e, input bit [6:0] f,
                        output int ge, output int gf, output int gs, output int lat, output int one);
    ge = -1; gf = -1; gs = -1; lat = -1;
    @(negedge clk);
    sign = s; exponent = e; fractional = f; input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        lat = n + 1;
        ge = e_res_o; gf = f_res_o; gs = s_res_o;
        break;
      end
    end
    @(posedge clk); #1;
    one = (valid_o == 1'b0 && ready_o == 1'b1) ? 1 : 0;
  endtask

  task automatic check_op(input string tag, input bit s, input bit [7:0] e, input bit [6:0] f,
                          input int we, input int wf, input int wl, input bit tol);
    int ge, gf, gs, lat, one;
    chk({tag, ".ready"}, int'(ready_o), 1);
    run_op(s, e, f, ge, gf, gs, lat, one);
    $display("op %s x=(%0d,%0d,%02h) -> (%0d,%0d,%02h) lat=%0d want (%0d,%02h) lat=%0d",
             tag, s, e, f, gs, ge, gf, lat, we, wf, wl);
    chk({tag, ".lat"}, lat, wl);
    chk({tag, ".sign"}, gs, 0);
    if (tol && wl == 14) chk_tol({tag, ".res"}, ge * 128 + gf, we * 128 + wf);
    else chk({tag, ".res"}, ge * 128 + gf, we * 128 + wf);
    chk({tag, ".onepulse"}, one, 1);
  endtask

  initial begin
    int acc[$];
    int vcnt, vseen, we, wf, wl;
    bit rs;
    bit [7:0] re;
    bit [6:0] rf;

    rst = 1'b1; sign = 1'b0; exponent = '0; fractional = '0; input_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ready", int'(ready_o), 1);
    chk("reset.valid", int'(valid_o), 0);
    chk("reset.res", int'(e_res_o) * 128 + int'(f_res_o), 0);
    chk("reset.sign", int'(s_res_o), 0);
    rst = 1'b0;

    check_op("one",     1'b0, 8'd127, 7'h00, 128, 8'h00, 14, 1'b0);
    check_op("mone",    1'b1, 8'd127, 7'h00, 126, 8'h00, 14, 1'b0);
    check_op("three",   1'b0, 8'd128, 7'h40, 130, 8'h00, 14, 1'b0);
    check_op("half",    1'b0, 8'd126, 7'h00, 127, 8'h35, 14, 1'b1);
    check_op("p128",    1'b0, 8'd134, 7'h00, 255, 8'h00, 2,  1'b0);
    check_op("m200",    1'b1, 8'd134, 7'h48, 0,   8'h00, 2,  1'b0);
    check_op("m126",    1'b1, 8'd133, 7'h7C, 1,   8'h00, 14, 1'b0);
    check_op("nan",     1'b1, 8'd255, 7'h11, 255, 8'h40, 2,  1'b0);
    check_op("pinf",    1'b0, 8'd255, 7'h00, 255, 8'h00, 2,  1'b0);
    check_op("minf",    1'b1, 8'd255, 7'h00, 0,   8'h00, 2,  1'b0);
    check_op("subn",    1'b0, 8'd0,   7'h05, 127, 8'h00, 2,  1'b0);
    check_op("big",     1'b0, 8'd140, 7'h10, 255, 8'h00, 2,  1'b0);

    for (int k = 0; k < 30; k++) begin
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) re = 8'($urandom_range(100, 136));
      else re = 8'($urandom_range(0, 255));
      rf = 7'($urandom_range(0, 127));
      model(rs, re, rf, we, wf, wl);
      check_op($sformatf("rnd%0d", k), rs, re, rf, we, wf, wl, 1'b1);
    end

    // input_valid held high: accepts every ITER+3 cycles, one result per accept
    @(negedge clk);
    sign = 1'b0; exponent = 8'd127; fractional = 7'h00; input_valid = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (ready_o) acc.push_back(c);
      if (valid_o) begin
        vcnt++;
        chk("stream.res", int'(e_res_o) * 128 + int'(f_res_o), 128 * 128);
      end
      @(negedge clk);
    end
    input_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (valid_o) vcnt++;
      @(negedge clk);
    end
    $display("op stream accepts=%0d valids=%0d", acc.size(), vcnt);
    chk("stream.accepts", acc.size(), 4);
    chk("stream.valids", vcnt, acc.size());
    for (int k = 1; k < acc.size(); k++) chk("stream.spacing", acc[k] - acc[k-1], 15);

    // reset in the middle of an operation
    check_op("prerst", 1'b0, 8'd127, 7'h00, 128, 8'h00, 14, 1'b0);
    @(negedge clk);
    sign = 1'b0; exponent = 8'd127; fractional = 7'h00; input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("op midreset valid=%0d e=%0d f=%0d ready=%0d", valid_o, e_res_o, f_res_o, ready_o);
    chk("rst.valid", int'(valid_o), 0);
    chk("rst.res", int'(e_res_o) * 128 + int'(f_res_o), 0);
    chk("rst.ready", int'(ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    vseen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid_o) vseen++;
    end
    chk("rst.novalid", vseen, 0);
    check_op("postrst", 1'b1, 8'd127, 7'h00, 126, 8'h00, 14, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
